// File: rtl/zdos_trap_if.sv
// Z80 bus signals seen by the DOS trap: address and fetch strobes.
// master drives (Z80 side), slave observes (zdos_trap).
interface zdos_trap_if;
    logic [15:0] za;
    logic        m1_n;
    logic        mreq_n;
    logic        rd_n;

    modport master (
        output za,
        output m1_n,
        output mreq_n,
        output rd_n
    );

    modport slave (
        input za,
        input m1_n,
        input mreq_n,
        input rd_n
    );
endinterface

// File: rtl/zdos_trap.sv
// DOS entry/exit trap: watches Z80 M1 fetches and pulses DOS on/off requests.
// Ports: fclk, rst_n, z80 (za/m1_n/mreq_n/rd_n), rom48_sel, trap_en, dos,
//        dos_turn_on, dos_turn_off, fetch_cnt.
module zdos_trap #(
    parameter int         FILT      = 2,
    parameter logic [7:0] TRAP_PAGE = 8'h3D
) (
    input  logic        fclk,
    input  logic        rst_n,
    zdos_trap_if.slave  z80,
    input  logic        rom48_sel,
    input  logic        trap_en,
    input  logic        dos,
    output logic        dos_turn_on,
    output logic        dos_turn_off,
    output logic [7:0]  fetch_cnt
);

    localparam logic [2:0] FILT_C = 3'(FILT);

    typedef enum logic [1:0] {
        IDLE,
        DECIDE,
        WAIT_END
    } state_t;

    state_t     state;
    state_t     state_d;

    logic [1:0] m1_q;
    logic [1:0] mreq_q;
    logic [1:0] rd_q;
    logic       fetch_s;
    logic [2:0] filt_cnt;
    logic       fetch_ok;
    logic       on_d;
    logic       off_d;
    logic       cnt_inc;

    // Two-flop synchronisers, preset to the inactive (high) level.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q   <= 2'b11;
            mreq_q <= 2'b11;
            rd_q   <= 2'b11;
        end else begin
            m1_q   <= {m1_q[0], z80.m1_n};
            mreq_q <= {mreq_q[0], z80.mreq_n};
            rd_q   <= {rd_q[0], z80.rd_n};
        end
    end

    assign fetch_s = ~m1_q[1] & ~mreq_q[1] & ~rd_q[1];

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= 3'd0;
        end else if (!fetch_s) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt != FILT_C) begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign fetch_ok = (filt_cnt == FILT_C);

    // The decision is computed on the edge that enters DECIDE, so the
    // registered pulse occupies exactly the DECIDE cycle. za is stable
    // by then (address leads MREQ), so it is used directly.
    always_comb begin
        state_d = state;
        on_d    = 1'b0;
        off_d   = 1'b0;
        cnt_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (fetch_ok) begin
                    state_d = DECIDE;
                    cnt_inc = 1'b1;
                    if (!dos && trap_en && rom48_sel &&
                        z80.za[15:8] == TRAP_PAGE) begin
                        on_d = 1'b1;
                    end else if (dos && z80.za[15:14] != 2'b00) begin
                        off_d = 1'b1;
                    end
                end
            end
            DECIDE: begin
                state_d = WAIT_END;
            end
            WAIT_END: begin
                if (!fetch_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            dos_turn_on  <= 1'b0;
            dos_turn_off <= 1'b0;
            fetch_cnt    <= 8'd0;
        end else begin
            state        <= state_d;
            dos_turn_on  <= on_d;
            dos_turn_off <= off_d;
            if (cnt_inc) begin
                fetch_cnt <= fetch_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_zdos_trap.sv
// Testbench for zdos_trap: directed scenarios plus random fetches
// checked against a transaction-level model of the trap rules.
module tb_zdos_trap;

    localparam int FILT = 2;
    localparam int LAT  = 2 + FILT + 1;

    logic       fclk;
    logic       rst_n;
    logic       rom48_sel;
    logic       trap_en;
    logic       dos;
    logic       dos_turn_on;
    logic       dos_turn_off;
    logic [7:0] fetch_cnt;

    int         n_chk;
    int         n_pass;
    logic [7:0] model_cnt;

    zdos_trap_if bus ();

    zdos_trap #(
        .FILT      (FILT),
        .TRAP_PAGE (8'h3D)
    ) dut (
        .fclk         (fclk),
        .rst_n        (rst_n),
        .z80          (bus.slave),
        .rom48_sel    (rom48_sel),
        .trap_en      (trap_en),
        .dos          (dos),
        .dos_turn_on  (dos_turn_on),
        .dos_turn_off (dos_turn_off),
        .fetch_cnt    (fetch_cnt)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic strobes_idle();
        bus.m1_n   = 1'b1;
        bus.mreq_n = 1'b1;
        bus.rd_n   = 1'b1;
    endtask

    // kind: 0 = opcode fetch, 1 = interrupt acknowledge, 2 = memory read
    task automatic run_fetch(input logic [15:0] a, input int hold,
                             input int kind);
        bit acc;
        bit exp_on;
        bit exp_off;
        int n_on;
        int n_off;
        int both;
        int t_on;
        int t_off;
        acc     = (kind == 0) && (hold >= FILT);
        exp_on  = acc && !dos && trap_en && rom48_sel && (a[15:8] == 8'h3D);
        exp_off = acc && dos && (a >= 16'h4000);
        if (acc) model_cnt = model_cnt + 8'd1;
        n_on  = 0;
        n_off = 0;
        both  = 0;
        t_on  = -1;
        t_off = -1;
        @(negedge fclk);
        bus.za = a;
        case (kind)
            0: begin
                bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
            end
            1: begin
                bus.m1_n = 1'b0; bus.mreq_n = 1'b1; bus.rd_n = 1'b1;
            end
            default: begin
                bus.m1_n = 1'b1; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
            end
        endcase
        for (int i = 1; i <= hold + 10; i++) begin
            @(posedge fclk);
            #1;
            if (dos_turn_on) begin
                n_on++;
                if (t_on < 0) t_on = i;
            end
            if (dos_turn_off) begin
                n_off++;
                if (t_off < 0) t_off = i;
            end
            if (dos_turn_on && dos_turn_off) both++;
            if (i == hold) strobes_idle();
        end
        check("on_pulses", n_on, {31'd0, exp_on});
        check("off_pulses", n_off, {31'd0, exp_off});
        check("both_high", both, 0);
        if (exp_on) check("on_latency", t_on, LAT);
        if (exp_off) check("off_latency", t_off, LAT);
        check("fetch_cnt", {24'd0, fetch_cnt}, {24'd0, model_cnt});
    endtask

    initial begin
        int n_on;
        int n_off;
        int t_on;
        logic [7:0] start_cnt;
        logic [15:0] a;
        n_chk     = 0;
        n_pass    = 0;
        model_cnt = 8'd0;
        rst_n     = 1'b0;
        dos       = 1'b0;
        trap_en   = 1'b1;
        rom48_sel = 1'b1;
        bus.za    = 16'h0000;
        strobes_idle();

        // 1: reset, then quiet bus
        repeat (3) @(posedge fclk);
        #1;
        check("rst_on", {31'd0, dos_turn_on}, 0);
        check("rst_off", {31'd0, dos_turn_off}, 0);
        check("rst_cnt", {24'd0, fetch_cnt}, 0);
        @(negedge fclk);
        rst_n = 1'b1;
        n_on  = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge fclk);
            #1;
            if (dos_turn_on || dos_turn_off) n_on++;
        end
        check("idle_pulses", n_on, 0);
        check("idle_cnt", {24'd0, fetch_cnt}, 0);

        // 2: trap entry
        run_fetch(16'h3D2F, 10, 0);
        // 3: blocked by rom48_sel, then by trap_en
        rom48_sel = 1'b0;
        run_fetch(16'h3D2F, 10, 0);
        rom48_sel = 1'b1;
        trap_en   = 1'b0;
        run_fetch(16'h3D2F, 10, 0);
        trap_en   = 1'b1;
        // 4: exit only from RAM
        dos = 1'b1;
        run_fetch(16'h1234, 10, 0);
        run_fetch(16'h8000, 10, 0);
        run_fetch(16'h4000, 6, 0);
        run_fetch(16'h3FFF, 6, 0);
        // 5: glitch, intack, memory read
        dos = 1'b0;
        run_fetch(16'h3D00, 1, 0);
        run_fetch(16'h3D00, 10, 1);
        run_fetch(16'h3D00, 10, 2);
        run_fetch(16'h3D00, FILT, 0);
        // 6: long wait-state fetch
        run_fetch(16'h3D10, 40, 0);

        // reset during WAIT_END with fetch still held
        @(negedge fclk);
        bus.za = 16'h3D2F;
        bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0;
        repeat (LAT + 3) @(posedge fclk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_on", {31'd0, dos_turn_on}, 0);
        check("midrst_off", {31'd0, dos_turn_off}, 0);
        check("midrst_cnt", {24'd0, fetch_cnt}, 0);
        model_cnt = 8'd0;
        @(negedge fclk);
        rst_n = 1'b1;
        n_on  = 0;
        n_off = 0;
        t_on  = -1;
        for (int i = 1; i <= 15; i++) begin
            @(posedge fclk);
            #1;
            if (dos_turn_on) begin
                n_on++;
                if (t_on < 0) t_on = i;
            end
            if (dos_turn_off) n_off++;
        end
        model_cnt = model_cnt + 8'd1;
        check("postrst_on", n_on, 1);
        check("postrst_lat", t_on, LAT);
        check("postrst_off", n_off, 0);
        check("postrst_cnt", {24'd0, fetch_cnt}, {24'd0, model_cnt});
        strobes_idle();
        repeat (6) @(posedge fclk);

        // random fetches against the rule model
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 2))
                0: a = {8'h3D, 8'($urandom_range(0, 255))};
                1: a = 16'($urandom_range(0, 16'h3FFF));
                default: a = 16'($urandom_range(16'h4000, 16'hFFFF));
            endcase
            dos       = 1'($urandom_range(0, 1));
            trap_en   = ($urandom_range(0, 3) != 0);
            rom48_sel = ($urandom_range(0, 3) != 0);
            run_fetch(a, $urandom_range(1, 12),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0);
        end

        // counter wrap over 256 accepted fetches
        dos       = 1'b0;
        start_cnt = fetch_cnt;
        for (int k = 0; k < 256; k++) begin
            run_fetch(16'h1234, FILT, 0);
        end
        check("wrap_cnt", {24'd0, fetch_cnt}, {24'd0, start_cnt});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
